// File: rtl/dot_mac_ctrl.sv
// Sequencer for the shared 8x8 MAC in the dot-product design: loads A/B vectors, then runs clear/accumulate/wait/capture.
// Optional macro DOT_SAT_EN: saturate the displayed result to all ones on overflow instead of truncating.
module dot_mac_ctrl #(
  parameter int N_ELEM  = 4,
  parameter int DATA_W  = 8,
  parameter int IDX_W   = 2,
  parameter int ACC_W   = 18,
  parameter int RES_W   = 16,
  parameter int MAC_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_a,
  input  logic              ld_b,
  input  logic [DATA_W-1:0] din,
  input  logic [IDX_W-1:0]  din_idx,
  input  logic              start,
  input  logic [ACC_W-1:0]  mac_acc,
  output logic              mac_clr,
  output logic              mac_en,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  output logic [RES_W-1:0]  result,
  output logic              oflow,
  output logic              busy,
  output logic              done,
  output logic              a_valid,
  output logic              b_valid
);

  localparam int LAT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);
  localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'(MAC_LAT - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    RUN  = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state, next_state;

  logic [DATA_W-1:0] vec_a [N_ELEM];
  logic [DATA_W-1:0] vec_b [N_ELEM];
  logic [IDX_W-1:0]  idx;
  logic [LAT_W-1:0]  lat_cnt;
  logic              ld_a_q, ld_b_q;
  logic              launch, leave_wait;
  logic              acc_ovf;

  assign acc_ovf = |mac_acc[ACC_W-1:RES_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    mac_clr    = 1'b0;
    mac_en     = 1'b0;
    mac_a      = '0;
    mac_b      = '0;
    busy       = 1'b0;
    done       = 1'b0;
    launch     = 1'b0;
    leave_wait = 1'b0;
    case (state)
      IDLE: begin
        if ((a_valid && b_valid) || start) begin
          next_state = CLR;
          launch     = 1'b1;
        end
      end
      CLR: begin
        mac_clr    = 1'b1;
        busy       = 1'b1;
        next_state = RUN;
      end
      RUN: begin
        mac_en = 1'b1;
        busy   = 1'b1;
        mac_a  = vec_a[idx];
        mac_b  = vec_b[idx];
        if (idx == LAST_IDX) next_state = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (lat_cnt == LAST_LAT) begin
          next_state = DONE;
          leave_wait = 1'b1;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ELEM; i++) begin
        vec_a[i] <= '0;
        vec_b[i] <= '0;
      end
      idx     <= '0;
      lat_cnt <= '0;
      ld_a_q  <= 1'b0;
      ld_b_q  <= 1'b0;
      a_valid <= 1'b0;
      b_valid <= 1'b0;
      result  <= '0;
      oflow   <= 1'b0;
    end else begin
      // Edge registers track the inputs in every state so a stale edge never surfaces later.
      ld_a_q <= ld_a;
      ld_b_q <= ld_b;
      case (state)
        IDLE: begin
          if (ld_a && !ld_b) vec_a[din_idx] <= din;
          if (ld_b && !ld_a) vec_b[din_idx] <= din;
          if (launch) begin
            a_valid <= 1'b0;
            b_valid <= 1'b0;
          end else begin
            // Only a falling edge that ends a solo load marks a vector complete.
            if (ld_a_q && !ld_b_q && !ld_a) a_valid <= 1'b1;
            if (ld_b_q && !ld_a_q && !ld_b) b_valid <= 1'b1;
          end
        end
        CLR: idx <= '0;
        RUN: begin
          idx     <= idx + IDX_W'(1);
          lat_cnt <= '0;
        end
        WAIT: begin
          if (leave_wait) begin
            oflow <= acc_ovf;
`ifdef DOT_SAT_EN
            result <= acc_ovf ? {RES_W{1'b1}} : mac_acc[RES_W-1:0];
`else
            result <= mac_acc[RES_W-1:0];
`endif
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_mac_ctrl.sv
// Directed bench for dot_mac_ctrl with a behavioural single-cycle MAC; hand-computed expected results.
module tb_dot_mac_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_a = 1'b0, ld_b = 1'b0, start = 1'b0;
  logic [7:0]  din = '0;
  logic [1:0]  din_idx = '0;
  logic [17:0] mac_acc;
  logic        mac_clr, mac_en, oflow, busy, done, a_valid, b_valid;
  logic [7:0]  mac_a, mac_b;
  logic [15:0] result;

  int n_cmp = 0;
  int n_err = 0;
  int n_cyc, n_clr, n_en, last_clr, first_en, n_done;

`ifdef DOT_SAT_EN
  localparam logic [15:0] SAT_RES = 16'hFFFF;
`else
  localparam logic [15:0] SAT_RES = 16'hF804;
`endif

  always #5 clk = ~clk;

  // Behavioural MAC with one cycle of latency.
  always @(posedge clk)
    mac_acc <= mac_clr ? 18'd0 : (mac_en ? mac_acc + {10'd0, mac_a} * {10'd0, mac_b} : mac_acc);
  initial mac_acc = '0;

  dot_mac_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ld_a(ld_a), .ld_b(ld_b), .din(din), .din_idx(din_idx),
    .start(start), .mac_acc(mac_acc), .mac_clr(mac_clr), .mac_en(mac_en), .mac_a(mac_a),
    .mac_b(mac_b), .result(result), .oflow(oflow), .busy(busy), .done(done),
    .a_valid(a_valid), .b_valid(b_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_vec(input bit sel_b, input logic [7:0] v0, v1, v2, v3);
    logic [7:0] v [4];
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    for (int i = 0; i < 4; i++) begin
      if (sel_b) ld_b = 1'b1; else ld_a = 1'b1;
      din_idx = 2'(i);
      din = v[i];
      @(negedge clk);
    end
    ld_a = 1'b0;
    ld_b = 1'b0;
    @(negedge clk);
  endtask

  // Step until done is seen (bounded), recording MAC control activity.
  task automatic wait_done();
    n_cyc = 0; n_clr = 0; n_en = 0; last_clr = -1; first_en = -1;
    while (n_cyc < 40) begin
      @(negedge clk);
      n_cyc++;
      if (mac_clr) begin n_clr++; last_clr = n_cyc; end
      if (mac_en) begin n_en++; if (first_en < 0) first_en = n_cyc; end
      if (done) break;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    // Reset values
    #3;
    check("rst_outputs", {mac_clr, mac_en, busy, done, a_valid, b_valid, oflow}, 32'd0);
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_operands", {16'd0, mac_a, mac_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic dot product 1,2,3,4 . 5,6,7,8 = 70
    load_vec(1'b0, 8'd1, 8'd2, 8'd3, 8'd4);
    check("a_valid_set", {31'd0, a_valid}, 32'd1);
    check("b_valid_idle", {31'd0, b_valid}, 32'd0);
    load_vec(1'b1, 8'd5, 8'd6, 8'd7, 8'd8);
    check("both_valid", {30'd0, a_valid, b_valid}, 32'd3);
    wait_done();
    check("latency1", n_cyc, 32'd7);
    check("result1", {16'd0, result}, 32'h0046);
    check("oflow1", {31'd0, oflow}, 32'd0);
    check("valid_cleared1", {30'd0, a_valid, b_valid}, 32'd0);
    @(negedge clk);
    check("done_one_cycle", {30'd0, done, busy}, 32'd0);

    // Second vector pair: 140+165+12+26 = 343
    load_vec(1'b0, 8'd10, 8'd11, 8'd12, 8'd13);
    load_vec(1'b1, 8'd14, 8'd15, 8'd1, 8'd2);
    wait_done();
    check("result2", {16'd0, result}, 32'h0157);
    check("oflow2", {31'd0, oflow}, 32'd0);
    check("clr_count", n_clr, 32'd1);
    check("en_count", n_en, 32'd4);
    check("clr_before_en", first_en, last_clr + 1);
    @(negedge clk);

    // Overflow: 4*255*255 = 0x3F804
    load_vec(1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    load_vec(1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    wait_done();
    check("oflow3", {31'd0, oflow}, 32'd1);
    check("result3", {16'd0, result}, {16'd0, SAT_RES});
    @(negedge clk);

    // start with no new load reruns; a second start while busy is dropped
    pulse_start();
    @(negedge clk);
    pulse_start();
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    check("single_done", n_done, 32'd1);
    check("result4", {16'd0, result}, {16'd0, SAT_RES});
    check("oflow4", {31'd0, oflow}, 32'd1);
    check("busy_idle4", {31'd0, busy}, 32'd0);

    // Both loads high: no write, no flag
    ld_a = 1'b1; ld_b = 1'b1; din_idx = 2'd0; din = 8'h77;
    @(negedge clk);
    @(negedge clk);
    ld_a = 1'b0; ld_b = 1'b0;
    @(negedge clk);
    check("dual_ld_no_flag", {30'd0, a_valid, b_valid}, 32'd0);

    // ld_b toggled during RUN must not write or flag
    pulse_start();
    ld_b = 1'b1; din_idx = 2'd0; din = 8'h00;
    @(negedge clk);
    @(negedge clk);
    ld_b = 1'b0;
    wait_done();
    check("ld_in_run_no_flag", {31'd0, b_valid}, 32'd0);
    check("ld_in_run_result", {16'd0, result}, {16'd0, SAT_RES});
    @(negedge clk);
    check("b_valid_after", {31'd0, b_valid}, 32'd0);

    // Rerun proves A[0]/B[0] unchanged by the dual load and the RUN-time load
    pulse_start();
    wait_done();
    check("unchanged_ab", {16'd0, result}, {16'd0, SAT_RES});
    @(negedge clk);

    // Reset mid-RUN plus a glitch train
    pulse_start();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrun_rst_ctrl", {mac_clr, mac_en, busy, done, a_valid, b_valid, oflow}, 32'd0);
    check("midrun_rst_data", {result, mac_a, mac_b}, 32'd0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1 rst_n = 1'b1;
    end
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check("no_done_after_rst", n_done, 32'd0);
    check("result_rst", {15'd0, oflow, result}, 32'd0);

    // Clean run after reset
    load_vec(1'b0, 8'd1, 8'd2, 8'd3, 8'd4);
    load_vec(1'b1, 8'd5, 8'd6, 8'd7, 8'd8);
    wait_done();
    check("result_post_rst", {16'd0, result}, 32'h0046);
    check("oflow_post_rst", {31'd0, oflow}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
